ball_bounce: RTL and testbench
==============================

BALL_BOUNCE -- requirements
Module: ball_bounce

Interface
REQ-001 The block SHALL have parameter S_SIZE, default 5, meaning ball half-size in pixels.
REQ-002 The block SHALL have parameter IX, default 320, meaning serve x of ball centre.
REQ-003 The block SHALL have parameter IY, default 400, meaning serve y of ball centre.
REQ-004 The block SHALL have parameter D_WIDTH, default 640, meaning display width.
REQ-005 The block SHALL have parameter D_HEIGHT, default 480, meaning display height.
REQ-006 The block SHALL have parameter P_TOP, default 440, meaning paddle top-edge y.
REQ-007 The block SHALL have port i_clk, input, 1 bit: the single base clock.
REQ-008 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 The block SHALL have port i_ani_stb, input, 1 bit: one-cycle animation strobe.
REQ-010 The block SHALL have port i_animate, input, 1 bit: motion enable.
REQ-011 The block SHALL have port mode, input, 1 bit: game active; low forces IDLE.
REQ-012 The block SHALL have port start, input, 1 bit: serve request.
REQ-013 The block SHALL have port hit_block, input, 2 bits: OR of all block hit codes (00 none, 01 vertical, 10 horizontal, 11 corner).
REQ-014 The block SHALL have ports i_px1 and i_px2, inputs, 12 bits each: paddle left and right edges.
REQ-015 The block SHALL have ports o_x and o_y, outputs, 12 bits each: ball centre, driving the blocks' s_x and s_y.
REQ-016 The block SHALL have ports o_x1, o_x2, o_y1 and o_y2, outputs, 12 bits each: ball edges (centre ± S_SIZE), combinational.
REQ-017 The block SHALL have port col_detected, output, 1 bit: hit acknowledge to the blocks.
REQ-018 The block SHALL have port o_hits, output, 9 bits: acknowledged-hit count.
REQ-019 The block SHALL have port o_lost, output, 1 bit: ball missed the paddle.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, ACK and LOST, all registered.
- IDLE: ball held at (IX,IY); start=1 with mode=1 -> RUN.
- RUN: a non-zero hit_block applies the reflection of REQ-022 and enters ACK in the same cycle.
- ACK: col_detected=1; hit_block==00 -> RUN; further non-zero codes while in ACK SHALL be ignored.
- LOST: o_lost=1, no motion; start=1 -> IDLE.
- mode=0 in any state -> IDLE on the next edge; ball reloads (IX,IY), directions and col_detected reset, o_hits kept.
REQ-021 Motion SHALL occur only in RUN or ACK, on cycles with i_ani_stb=1 and i_animate=1: x and y each step ±1 according to direction bits dx (1=right) and dy (1=down).
REQ-022 Reflection SHALL be: 01 inverts dy; 10 inverts dx; 11 inverts both; it is applied once per hit, and o_hits increments once per RUN->ACK transition, saturating at 511.
REQ-023 Walls SHALL set absolute directions, evaluated after the reflection so that walls win on their axis in the same cycle: x<=S_SIZE -> dx=1; x>=D_WIDTH-1-S_SIZE -> dx=0; y<=S_SIZE -> dy=1.
REQ-024 Paddle bounce SHALL occur when dy=1, y+S_SIZE==P_TOP and i_px1<=x<=i_px2 (inclusive): set dy=0.
REQ-025 When y+S_SIZE>=D_HEIGHT the FSM SHALL go to LOST; this takes priority over hits and the paddle.
REQ-026 Position arithmetic SHALL be 12-bit unsigned, and walls SHALL prevent any wrap.

Reset
REQ-027 While i_rst=1 the block SHALL hold: state=IDLE, x=IX, y=IY, dx=1, dy=0 (up), col_detected=0, o_hits=0, o_lost=0; reset mid-ACK SHALL drop col_detected immediately.

Structure
REQ-028 The hit-code constants (NONE/VERT/HORZ/CORNER) and state encodings SHALL live in a shared package also used by block.
REQ-029 One sub-module, ball_reflect, SHALL be combinational: it takes hit code, position and directions and returns the next dx and dy.

Verification
REQ-030 Hold case: reset, mode=1, start=1 -> RUN; with no i_ani_stb the ball SHALL stay at (320,400).
REQ-031 Vertical hit: hit_block=01 held for 3 cycles in RUN -> dy toggles exactly once, col_detected=1 until hit_block=00, o_hits=1.
REQ-032 Corner hit: hit_block=11 with dx=1, dy=0 -> dx=0, dy=1, o_hits+1.
REQ-033 Wall beats hit: x=5, dx=0 and hit_block=10 in the same cycle -> dx=1, not 0.
REQ-034 Paddle boundary: y=435, dy=1, x=i_px1=100 -> dy=0; x=99 -> LOST once y reaches 475, o_lost=1.
REQ-035 Reset mid-ACK: assert i_rst during ACK -> col_detected=0 and position (320,400) immediately.

Source files
------------

// File: rtl/ball_bounce_pkg.sv
// ball_bounce_pkg: shared hit codes, FSM states and sizing constants for the ball and the blocks
// Exports: hit_t (NONE/VERT/HORZ/CORNER), state_t (IDLE/RUN/ACK/LOST), PW, HW, HITS_MAX
package ball_bounce_pkg;
    localparam int PW = 12;
    localparam int HW = 9;
    localparam logic [HW-1:0] HITS_MAX = 9'd511;
    typedef enum logic [1:0] {NONE = 2'b00, VERT = 2'b01, HORZ = 2'b10, CORNER = 2'b11} hit_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ACK = 2'd2, LOST = 2'd3} state_t;
endpackage

// File: rtl/ball_bounce_if.sv
// ball_bounce_if: control, paddle, block-hit and ball-position signals of the ball
// master: drives i_ani_stb, i_animate, mode, start, hit_block, i_px1, i_px2; reads ball outputs
// slave:  the ball itself; drives o_x/o_y, edges o_x1/o_x2/o_y1/o_y2, col_detected, o_hits, o_lost
interface ball_bounce_if;
    import ball_bounce_pkg::*;
    logic          i_ani_stb;
    logic          i_animate;
    logic          mode;
    logic          start;
    logic [1:0]    hit_block;
    logic [PW-1:0] i_px1;
    logic [PW-1:0] i_px2;
    logic [PW-1:0] o_x;
    logic [PW-1:0] o_y;
    logic [PW-1:0] o_x1;
    logic [PW-1:0] o_x2;
    logic [PW-1:0] o_y1;
    logic [PW-1:0] o_y2;
    logic          col_detected;
    logic [HW-1:0] o_hits;
    logic          o_lost;
    modport master (
        output i_ani_stb, i_animate, mode, start, hit_block, i_px1, i_px2,
        input  o_x, o_y, o_x1, o_x2, o_y1, o_y2, col_detected, o_hits, o_lost
    );
    modport slave (
        input  i_ani_stb, i_animate, mode, start, hit_block, i_px1, i_px2,
        output o_x, o_y, o_x1, o_x2, o_y1, o_y2, col_detected, o_hits, o_lost
    );
endinterface

// File: rtl/ball_reflect.sv
// ball_reflect: combinational next-direction logic (hit reflection, then walls, then paddle)
// Inputs: hit (already gated to NONE when no new hit), x/y centre, px1/px2 paddle edges, dx/dy
// Outputs: dx_n/dy_n next directions (dx 1=right, dy 1=down)
module ball_reflect
    import ball_bounce_pkg::*;
#(
    parameter int S_SIZE  = 5,
    parameter int D_WIDTH = 640,
    parameter int P_TOP   = 440
) (
    input  hit_t          hit,
    input  logic [PW-1:0] x,
    input  logic [PW-1:0] y,
    input  logic [PW-1:0] px1,
    input  logic [PW-1:0] px2,
    input  logic          dx,
    input  logic          dy,
    output logic          dx_n,
    output logic          dy_n
);
    localparam logic [PW-1:0] LO = PW'(S_SIZE);
    localparam logic [PW-1:0] XHI = PW'(D_WIDTH - 1 - S_SIZE);
    localparam logic [PW-1:0] PY = PW'(P_TOP - S_SIZE);
    logic dx_r, dy_r, on_pad;
    always_comb begin
        dx_r = (hit == HORZ || hit == CORNER) ? ~dx : dx;
        dy_r = (hit == VERT || hit == CORNER) ? ~dy : dy;
        on_pad = dy_r && y == PY && x >= px1 && x <= px2;
        // walls override the reflection on their own axis
        dx_n = x <= LO ? 1'b1 : x >= XHI ? 1'b0 : dx_r;
        dy_n = y <= LO ? 1'b1 : on_pad ? 1'b0 : dy_r;
    end
endmodule

// File: rtl/ball_bounce.sv
// ball_bounce: ball position/direction FSM with block-hit acknowledge, walls, paddle and miss detect
// Ports: i_clk, i_rst (async, active-high), bus (ball_bounce_if.slave: control in, ball state out)
module ball_bounce
    import ball_bounce_pkg::*;
#(
    parameter int S_SIZE   = 5,
    parameter int IX       = 320,
    parameter int IY       = 400,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480,
    parameter int P_TOP    = 440
) (
    input logic          i_clk,
    input logic          i_rst,
    ball_bounce_if.slave bus
);
    localparam logic [PW-1:0] SX = PW'(S_SIZE);
    localparam logic [PW-1:0] X0 = PW'(IX);
    localparam logic [PW-1:0] Y0 = PW'(IY);
    localparam logic [PW-1:0] YL = PW'(D_HEIGHT - S_SIZE);
    state_t        st, st_n;
    logic [PW-1:0] x, y, x_n, y_n;
    logic          dx, dy, dx_n, dy_n, dx_b, dy_b;
    logic [HW-1:0] hits, hits_n;
    logic          lose, hit_new, mv;
    hit_t          hit_in, hit_g;
    assign hit_in = hit_t'(bus.hit_block);
    assign lose = y >= YL;
    assign mv = bus.i_ani_stb & bus.i_animate;
    // a hit counts only on the RUN->ACK edge; a miss outranks it
    assign hit_new = bus.mode && st == RUN && hit_in != NONE && !lose;
    assign hit_g = hit_new ? hit_in : NONE;
    ball_reflect #(
        .S_SIZE (S_SIZE),
        .D_WIDTH(D_WIDTH),
        .P_TOP  (P_TOP)
    ) u_reflect (
        .hit (hit_g),
        .x   (x),
        .y   (y),
        .px1 (bus.i_px1),
        .px2 (bus.i_px2),
        .dx  (dx),
        .dy  (dy),
        .dx_n(dx_b),
        .dy_n(dy_b)
    );
    always_comb begin
        st_n = st;
        x_n = x;
        y_n = y;
        dx_n = dx;
        dy_n = dy;
        hits_n = hits;
        case (st)
            IDLE: st_n = bus.start ? RUN : IDLE;
            RUN, ACK: begin
                if (lose) begin
                    st_n = LOST;
                end else begin
                    dx_n = dx_b;
                    dy_n = dy_b;
                    // stepping with the new directions keeps walls from wrapping the position
                    x_n = mv ? (dx_b ? x + 12'd1 : x - 12'd1) : x;
                    y_n = mv ? (dy_b ? y + 12'd1 : y - 12'd1) : y;
                    st_n = hit_new ? ACK : (st == ACK && hit_in == NONE) ? RUN : st;
                    hits_n = (hit_new && hits != HITS_MAX) ? hits + 9'd1 : hits;
                end
            end
            LOST: st_n = bus.start ? IDLE : LOST;
            default: st_n = IDLE;
        endcase
        if (!bus.mode) st_n = IDLE;
        // every entry to IDLE reloads the serve position and directions
        if (st_n == IDLE) begin
            x_n = X0;
            y_n = Y0;
            dx_n = 1'b1;
            dy_n = 1'b0;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st <= IDLE;
            x <= X0;
            y <= Y0;
            dx <= 1'b1;
            dy <= 1'b0;
            hits <= '0;
        end else begin
            st <= st_n;
            x <= x_n;
            y <= y_n;
            dx <= dx_n;
            dy <= dy_n;
            hits <= hits_n;
        end
    end
    assign bus.o_x = x;
    assign bus.o_y = y;
    assign bus.o_x1 = x - SX;
    assign bus.o_x2 = x + SX;
    assign bus.o_y1 = y - SX;
    assign bus.o_y2 = y + SX;
    assign bus.col_detected = st == ACK;
    assign bus.o_lost = st == LOST;
    assign bus.o_hits = hits;
endmodule

// File: tb/tb_ball_bounce.sv
// tb_ball_bounce: directed checks of ball_bounce (hold, hits, walls, paddle, miss, reset, saturation)
module tb_ball_bounce;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    ball_bounce_if b1 ();
    ball_bounce_if b2 ();
    ball_bounce dut1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
    ball_bounce #(.IX(98), .IY(433)) dut2 (.i_clk(clk), .i_rst(rst), .bus(b2.slave));
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic p1(input string t, input int ex, input int ey);
        chk({t, "_x"}, int'(b1.o_x), ex);
        chk({t, "_y"}, int'(b1.o_y), ey);
    endtask
    task automatic step1(input int n);
        b1.i_ani_stb = 1'b1;
        tick(n);
        b1.i_ani_stb = 1'b0;
    endtask
    task automatic step2(input int n);
        b2.i_ani_stb = 1'b1;
        tick(n);
        b2.i_ani_stb = 1'b0;
    endtask
    task automatic hit1(input logic [1:0] h);
        b1.hit_block = h;
        tick();
        b1.hit_block = 2'b00;
        tick();
    endtask
    initial begin
        {b1.i_ani_stb, b1.mode, b1.start, b1.hit_block} = '0;
        {b2.i_ani_stb, b2.mode, b2.start, b2.hit_block} = '0;
        b1.i_animate = 1'b1;
        b2.i_animate = 1'b1;
        b1.i_px1 = 12'd100;
        b1.i_px2 = 12'd200;
        b2.i_px1 = 12'd100;
        b2.i_px2 = 12'd150;
        tick(2);
        p1("rst", 320, 400);
        chk("rst_x1", int'(b1.o_x1), 315);
        chk("rst_x2", int'(b1.o_x2), 325);
        chk("rst_y1", int'(b1.o_y1), 395);
        chk("rst_y2", int'(b1.o_y2), 405);
        chk("rst_col", int'(b1.col_detected), 0);
        chk("rst_hits", int'(b1.o_hits), 0);
        chk("rst_lost", int'(b1.o_lost), 0);
        rst = 1'b0;
        b1.mode = 1'b1;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        tick(5);
        p1("hold", 320, 400);
        chk("hold_col", int'(b1.col_detected), 0);
        b1.hit_block = 2'b01;
        tick();
        chk("v_col1", int'(b1.col_detected), 1);
        chk("v_hits1", int'(b1.o_hits), 1);
        tick(2);
        chk("v_col3", int'(b1.col_detected), 1);
        chk("v_hits3", int'(b1.o_hits), 1);
        b1.hit_block = 2'b00;
        tick();
        chk("v_col_off", int'(b1.col_detected), 0);
        step1(1);
        p1("v_move", 321, 401);
        hit1(2'b01);
        b1.hit_block = 2'b11;
        tick();
        chk("c_hits", int'(b1.o_hits), 3);
        b1.hit_block = 2'b00;
        tick();
        step1(1);
        p1("c_move", 320, 402);
        hit1(2'b01);
        step1(315);
        p1("w_pre", 5, 87);
        b1.hit_block = 2'b10;
        b1.i_ani_stb = 1'b1;
        tick();
        b1.hit_block = 2'b00;
        b1.i_ani_stb = 1'b0;
        p1("w_hit", 6, 86);
        chk("w_hits", int'(b1.o_hits), 5);
        chk("w_col", int'(b1.col_detected), 1);
        tick();
        hit1(2'b01);
        step1(221);
        p1("pm_mid", 227, 307);
        hit1(2'b10);
        step1(128);
        p1("pm_edge", 99, 435);
        step1(40);
        p1("pm_bottom", 59, 475);
        chk("pm_lost0", int'(b1.o_lost), 0);
        step1(1);
        chk("pm_lost1", int'(b1.o_lost), 1);
        step1(3);
        p1("pm_frozen", 59, 475);
        chk("pm_lost2", int'(b1.o_lost), 1);
        chk("pm_hits", int'(b1.o_hits), 7);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        p1("re_idle", 320, 400);
        chk("re_lost", int'(b1.o_lost), 0);
        chk("re_hits", int'(b1.o_hits), 7);
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        step1(3);
        p1("run3", 323, 397);
        b1.mode = 1'b0;
        tick();
        p1("mode_off", 320, 400);
        chk("mode_off_hits", int'(b1.o_hits), 7);
        step1(2);
        p1("mode_off_hold", 320, 400);
        b1.mode = 1'b1;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        b1.hit_block = 2'b01;
        tick();
        chk("ra_col1", int'(b1.col_detected), 1);
        step1(2);
        p1("ra_move", 322, 402);
        rst = 1'b1;
        #1;
        chk("ra_col0", int'(b1.col_detected), 0);
        p1("ra_pos", 320, 400);
        chk("ra_hits", int'(b1.o_hits), 0);
        b1.hit_block = 2'b00;
        b1.mode = 1'b0;
        tick(2);
        rst = 1'b0;
        b2.mode = 1'b1;
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        b2.hit_block = 2'b01;
        tick();
        b2.hit_block = 2'b00;
        tick();
        step2(2);
        chk("pad_at_x", int'(b2.o_x), 100);
        chk("pad_at_y", int'(b2.o_y), 435);
        step2(1);
        chk("pad_bounce_x", int'(b2.o_x), 101);
        chk("pad_bounce_y", int'(b2.o_y), 434);
        chk("pad_lost", int'(b2.o_lost), 0);
        repeat (520) begin
            b2.hit_block = 2'b01;
            tick();
            b2.hit_block = 2'b00;
            tick();
        end
        chk("sat_hits", int'(b2.o_hits), 511);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
